bifrost_irqc: RTL
=================

# bifrost_irqc

Parametrised interrupt controller for BIFRÖST that replaces the fixed AND of VIA/UART interrupt lines with a register-programmable block. It synchronises up to 32 active-low interrupt sources and latches them per channel in level or edge mode. Sources are masked and combined into the 6502 IRQB line. The CPU reads and writes it through a byte-wide register window inside the BIFRÖST chip-select range.

## Interface
Parameters:
- N_IRQ, 8, number of interrupt channels, 1..32.
- LANES, derived as ceil(N_IRQ/8), byte lanes per register; not user-set.

Ports:
- clock  in  1  system clock (CPU phase clock, `clockout` at top level); all state on rising edge.
- reset  in  1  asynchronous, active-high; one clock, async active-high reset, no other clocks.
- irq_in_n  in  N_IRQ  raw source interrupt lines, active-low, asynchronous to clock.
- cs_n  in  1  register window select, active-low.
- rw  in  1  6502 convention: 1 = read, 0 = write.
- addr  in  5  addr[4:2] = register index, addr[1:0] = byte lane.
- wdata  in  8  write data.
- rdata  out  8  read data, combinational; top level gates it onto the bus.
- irq_n  out  1  combined interrupt to 6502 IRQB, active-low, registered.
- nmi_n  out  1  NMI request, active-low, registered; only with IRQC_NMI_EN, otherwise tied 1.

## Operation
- Each channel passes through a 2-flop synchroniser. Reset value is deasserted (1). `asserted` = ~sync output.
- Pending bit per channel is updated every clock:
  - Level mode (MODE=0): pend <= asserted.
  - Edge mode (MODE=1): pend <= (pend & ~clr) | rise | force.
  - rise = asserted & ~asserted_prev.
  - Set beats clear in the same cycle.
- Writes happen on a rising edge when cs_n=0 and rw=0. They are idempotent, so a write held for several cycles is harmless. Reads have no side effects.
- Registers, 32 bits each and byte lane selected by addr[1:0]:
  - Lanes ≥ LANES and bits ≥ N_IRQ read 0; writes to them are ignored.
  - 0 STATUS: read = pend. Write 1 = clear (clr) for edge-mode channels; no effect on level-mode channels.
  - 1 ENABLE: R/W mask, reset 0.
  - 2 MODE: R/W, 1 = edge, 0 = level, reset 0. A channel switching level→edge starts with pend = 0.
  - 3 FORCE: write 1 = set pend (force) on edge-mode channels; reads 0.
  - 4 VECTOR: read only, lane 0 only = {valid, 2'b00, idx[4:0]}, where idx is the lowest-numbered channel with pend & enable. Reads 8'h00 when nothing is active.
  - 5 ACTIVE: read only, pend & enable.
  - 6, 7: read 0.
- irq_n <= ~|(pend & enable & irq_mask), where irq_mask excludes channel 0 only under IRQC_NMI_EN.
- Reset values: pend 0, ENABLE 0, MODE 0, irq_n 1, nmi_n 1, rdata follows registers (8'h00 at STATUS).
- Reset asserted mid-operation clears all state immediately; irq_n goes to 1 asynchronously.

## Timing
- A source driven low before rising edge E0 is captured as follows: sync1 at E0, sync2 at E1, pend at E2, irq_n low at E3 (3-cycle latency).
- Level mode: a source released before edge F0 gives irq_n high at F3, provided no other channel is active.
- Edge mode: pend stays set after the source releases, until STATUS is written with 1.
- A STATUS/ENABLE/FORCE write at edge W changes pend/enable at W; irq_n follows at W+1.
- A rise and a clr in the same cycle leave pend = 1.
- Pulses shorter than one clock period may be missed; the minimum assertion is 2 clocks.
- VECTOR and ACTIVE reflect pend/enable combinationally, with no extra latency after the register update.

## Configuration
- IRQC_NMI_EN defined:
  - Channel 0 is hard-wired to edge mode (MODE bit 0 reads 1; writes ignored) and excluded from irq_n.
  - nmi_n <= ~(pend[0] & enable[0]). The CPU clears it via STATUS bit 0; each new falling edge produces a fresh NMI.
- IRQC_NMI_EN undefined:
  - Channel 0 is an ordinary channel.
  - nmi_n is constant 1.

## Test plan
- Reset, then N_IRQ=8: read regs 0–5 lane 0 → 00 each; irq_n=1. Write ENABLE=FF and hold irq_in_n=FF → irq_n stays 1.
- Level mode: ENABLE=04, drive irq_in_n[2] low at E0 → irq_n low at E3, VECTOR=82, ACTIVE=04. Release → irq_n high 3 clocks later, STATUS=00.
- Edge mode: MODE=08, ENABLE=08, pulse irq_in_n[3] low for 2 clocks → STATUS=08 stays set and irq_n stays low. Write STATUS=08 → irq_n high next clock.
- Simultaneous: channel 3 edge-pending, new rise on 3 in the same cycle as a STATUS=08 write → STATUS still 08. FORCE=20 with MODE=20 → STATUS bit 5 set; FORCE on a level channel → no effect.
- N_IRQ=20: drive channel 17 low with ENABLE lane 2 = 02 → VECTOR=91, ACTIVE lane 2 = 02. Lane 3 reads 00; write lane 3 is ignored.
- IRQC_NMI_EN: ENABLE=01, channel 0 falls → nmi_n low, irq_n stays 1. Write STATUS=01 → nmi_n high. Assert reset mid-pending → nmi_n and irq_n high immediately.

Source files
------------

// File: rtl/bifrost_irqc.sv
// BIFROST interrupt controller: synchronises active-low sources, latches them per channel
// (level/edge), masks and combines them into IRQB. Optional build macro: IRQC_NMI_EN.
module bifrost_irqc #(
    parameter int N_IRQ = 8,
    localparam int LANES = (N_IRQ + 7) / 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in_n,
    input  logic             cs_n,
    input  logic             rw,
    input  logic [4:0]       addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    output logic             irq_n,
    output logic             nmi_n
);

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_ENABLE = 3'd1;
    localparam logic [2:0] REG_MODE   = 3'd2;
    localparam logic [2:0] REG_FORCE  = 3'd3;
    localparam logic [2:0] REG_VECTOR = 3'd4;
    localparam logic [2:0] REG_ACTIVE = 3'd5;

    logic [N_IRQ-1:0] sync1_q, sync2_q, prev_q;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] enable_q, enable_d;
    logic [N_IRQ-1:0] mode_q, mode_d, mode_eff, mode_fix;
    logic [N_IRQ-1:0] asserted, rise, clr, frc, switch_on, active, irq_mask;
    logic [N_IRQ-1:0] wmask, wval, ch0;
    logic             irq_n_q, nmi_n_q;
    logic             wr_en, lane_ok;
    logic [2:0]       reg_sel;
    logic [4:0]       vec_idx;
    logic [7:0]       vec_byte;
    logic [31:0]      rd_word;

    assign wr_en   = ~cs_n & ~rw;
    assign reg_sel = addr[4:2];
    assign lane_ok = ({1'b0, addr[1:0]} < 3'(LANES));

    always_comb begin
        ch0    = '0;
        ch0[0] = 1'b1;
    end

`ifdef IRQC_NMI_EN
    // Channel 0 is the NMI source: always edge-latched and kept off IRQB.
    assign mode_fix = ch0;
    assign irq_mask = ~ch0;
`else
    assign mode_fix = '0;
    assign irq_mask = '1;
`endif

    assign asserted = ~sync2_q;
    assign rise     = asserted & ~prev_q;
    assign mode_eff = mode_q | mode_fix;
    assign active   = pend_q & enable_q;

    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_chan
        assign wval[gi]  = wdata[gi % 8];
        assign wmask[gi] = lane_ok && (addr[1:0] == 2'(gi / 8));
        // A channel entering edge mode starts clean; otherwise set wins over clear.
        assign pend_d[gi] = switch_on[gi] ? 1'b0 :
                            mode_eff[gi]  ? ((pend_q[gi] & ~clr[gi]) | rise[gi] | frc[gi]) :
                                            asserted[gi];
    end

    assign clr       = (wr_en && reg_sel == REG_STATUS) ? (wval & wmask) : '0;
    assign frc       = (wr_en && reg_sel == REG_FORCE)  ? (wval & wmask) : '0;
    assign enable_d  = (wr_en && reg_sel == REG_ENABLE) ? ((enable_q & ~wmask) | (wval & wmask)) : enable_q;
    assign mode_d    = ((wr_en && reg_sel == REG_MODE) ? ((mode_q & ~wmask) | (wval & wmask)) : mode_q)
                       | mode_fix;
    assign switch_on = mode_d & ~mode_eff;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            prev_q   <= '0;
            pend_q   <= '0;
            enable_q <= '0;
            mode_q   <= '0;
            irq_n_q  <= 1'b1;
            nmi_n_q  <= 1'b1;
        end else begin
            sync1_q  <= irq_in_n;
            sync2_q  <= sync1_q;
            prev_q   <= asserted;
            pend_q   <= pend_d;
            enable_q <= enable_d;
            mode_q   <= mode_d;
            irq_n_q  <= ~|(pend_q & enable_q & irq_mask);
`ifdef IRQC_NMI_EN
            nmi_n_q  <= ~(pend_q[0] & enable_q[0]);
`else
            nmi_n_q  <= 1'b1;
`endif
        end
    end

    // Lowest-numbered active channel wins the vector.
    always_comb begin
        vec_idx = 5'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (active[i]) vec_idx = 5'(i);
        end
        vec_byte = (|active) ? {1'b1, 2'b00, vec_idx} : 8'h00;
    end

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_STATUS: rd_word = 32'(pend_q);
            REG_ENABLE: rd_word = 32'(enable_q);
            REG_MODE:   rd_word = 32'(mode_eff);
            REG_VECTOR: rd_word = (addr[1:0] == 2'd0) ? {24'd0, vec_byte} : 32'd0;
            REG_ACTIVE: rd_word = 32'(active);
            default:    rd_word = '0;
        endcase
        rdata = rd_word[{addr[1:0], 3'b000} +: 8];
    end

    assign irq_n = irq_n_q;
    assign nmi_n = nmi_n_q;

endmodule
